// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings and the
// watchdog limit used when MEM_ARB_TIMEOUT_EN is defined.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_ISSUE = 3'd1,
    D_WAIT  = 3'd2,
    I_ISSUE = 3'd3,
    I_WAIT  = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Wait-state watchdog for the memory arbiter. Only built when
// MEM_ARB_TIMEOUT_EN is defined; without it the arbiter waits forever.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  // Count wait cycles, saturating at the limit; cleared at each new issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TIMEOUT_LIMIT)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = en && (count == TIMEOUT_LIMIT);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data requests win over fetch; each access is ISSUE (one strobe cycle)
// followed by WAIT until mem_done, then a one-cycle done pulse.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a wait-state watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        err
);

  state_t      state_q, next_state;
  logic [15:0] addr_q, wdata_q;
  logic        is_write_q;
  logic [15:0] if_rdata_q, dm_rdata_q;
  logic        if_done_q, dm_done_q;
  logic        err_q;
  logic        in_issue, in_wait, timeout, err_event;

  assign in_issue = (state_q == D_ISSUE) || (state_q == I_ISSUE);
  assign in_wait  = (state_q == D_WAIT)  || (state_q == I_WAIT);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (in_issue),
    .en      (in_wait),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Stray completions, a simultaneous load+store, or a watchdog expiry all flag err.
  assign err_event = (mem_done && ((state_q == IDLE) || in_issue))
                   || ((state_q == IDLE) && dm_rd && dm_wr)
                   || (in_wait && !mem_done && timeout);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and memory strobes; strobes are only ever high in ISSUE.
  always_comb begin
    next_state = state_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_rd || dm_wr) begin
          next_state = D_ISSUE;
        end else if (if_req) begin
          next_state = I_ISSUE;
        end
      end
      D_ISSUE: begin
        mem_rd     = !is_write_q;
        mem_wr     = is_write_q;
        next_state = D_WAIT;
      end
      I_ISSUE: begin
        mem_rd     = 1'b1;
        next_state = I_WAIT;
      end
      D_WAIT, I_WAIT: begin
        if (mem_done || timeout) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture, read-data return, done pulses and the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (dm_rd || dm_wr) begin
          addr_q     <= dm_addr;
          wdata_q    <= dm_wdata;
          is_write_q <= dm_wr && !dm_rd;
        end else if (if_req) begin
          addr_q <= if_addr;
        end
      end
      if (mem_done && (state_q == D_WAIT)) begin
        dm_done_q <= 1'b1;
        if (!is_write_q) begin
          dm_rdata_q <= mem_rdata;
        end
      end
      if (mem_done && (state_q == I_WAIT)) begin
        if_done_q  <= 1'b1;
        if_rdata_q <= mem_rdata;
      end
      if (err_event) begin
        err_q <= 1'b1;
      end
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign stall     = (if_req && !if_done) || ((dm_rd || dm_wr) && !dm_done);

endmodule
